// File: rtl/md_unit_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default latencies
// and the controller state type.
package md_unit_ctrl_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W           = 8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } md_state_e;

  function automatic logic is_long_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath. Produces {hi,lo} for mult/multu/div/divu
// and flags a zero divisor so the controller can skip the commit.
module md_arith
  import md_unit_ctrl_pkg::*;
(
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic [63:0] result,
  output logic        div0
);

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic               ovf;
  logic [31:0]        divisor;
  logic [31:0]        quo_s;
  logic [31:0]        rem_s;
  logic [31:0]        quo_u;
  logic [31:0]        rem_u;

  assign div0 = is_div_op(md_op) && (src_b == 32'd0);
  assign ovf  = (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);

  assign prod_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
  assign prod_u = {32'd0, src_a} * {32'd0, src_b};

  // Substitute a divisor of 1 for the two cases the divider must never see.
  assign divisor = ((src_b == 32'd0) || ovf) ? 32'd1 : src_b;

  always_comb begin
    quo_s = $signed(src_a) / $signed(divisor);
    rem_s = $signed(src_a) % $signed(divisor);
    if (ovf) begin
      quo_s = 32'h8000_0000;
      rem_s = 32'd0;
    end
    quo_u = src_a / divisor;
    rem_u = src_a % divisor;
  end

  always_comb begin
    result = 64'd0;
    case (md_op)
      MD_MULT:  result = prod_s;
      MD_MULTU: result = prod_u;
      MD_DIV:   result = {rem_s, quo_s};
      MD_DIVU:  result = {rem_u, quo_u};
      default:  result = 64'd0;
    endcase
  end

endmodule

// File: rtl/md_unit_ctrl.sv
// E-stage multiply/divide sequencer: owns HI/LO, models mult/div latency with a
// down-counter, and requests a stall while a D-stage HI/LO user must wait.
//
//   state  | meaning
//   S_IDLE | no op in flight; accepts new md ops, mthi/mtlo write directly
//   S_BUSY | mult/div in flight; counter runs down, commit at terminal count 1
module md_unit_ctrl
  import md_unit_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  input  logic        d_uses_md,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_e        state;
  md_state_e        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [63:0]      pend;
  logic             pend_div0;
  logic [63:0]      arith_res;
  logic             arith_div0;
  logic             accept;
  logic             long_op;
  logic             tc;

  md_arith u_md_arith (
    .md_op  (md_op),
    .src_a  (src_a),
    .src_b  (src_b),
    .result (arith_res),
    .div0   (arith_div0)
  );

  assign busy    = (state == S_BUSY);
  assign accept  = start && !flush && !busy;
  assign long_op = is_long_op(md_op);
  assign tc      = (cnt == CNT_W'(1));
  assign stall   = d_uses_md && (busy || (start && !flush && long_op));

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept && long_op) state_nxt = S_BUSY;
      S_BUSY:  if (tc) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      pend      <= 64'd0;
      pend_div0 <= 1'b0;
      hi        <= 32'd0;
      lo        <= 32'd0;
    end else begin
      if (accept && long_op) begin
        cnt       <= is_div_op(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        pend      <= arith_res;
        pend_div0 <= arith_div0;
      end else if (busy) begin
        cnt <= cnt - CNT_W'(1);
        // A zero divisor still burns the full latency but leaves HI/LO alone.
        if (tc && !pend_div0) begin
          hi <= pend[63:32];
          lo <= pend[31:0];
        end
      end
      if (accept && (md_op == MD_MTHI)) hi <= src_a;
      if (accept && (md_op == MD_MTLO)) lo <= src_a;
    end
  end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Self-checking bench for md_unit_ctrl: expected HI/LO pushed to a scoreboard at
// issue and popped when the operation retires.
module tb_md_unit_ctrl;
  import md_unit_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        flush = 1'b0;
  logic        d_uses_md = 1'b0;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_err = 0;
  int          n_chk = 0;
  logic [63:0] sb_q[$];
  logic [31:0] mdl_hi = 32'd0;
  logic [31:0] mdl_lo = 32'd0;

  md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .md_op     (md_op),
    .src_a     (src_a),
    .src_b     (src_b),
    .flush     (flush),
    .d_uses_md (d_uses_md),
    .busy      (busy),
    .stall     (stall),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  assert property (@(posedge clk) disable iff (reset) !(start && busy))
    else $error("start asserted while busy");

  initial begin
    #500000;
    $display("FAIL timeout: got no finish, required finish before 500us");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] h,
                                        input logic [31:0] l);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = {h, l};
    case (op)
      MD_MULT:  res = sa * sb;
      MD_MULTU: res = {32'd0, a} * {32'd0, b};
      MD_DIV:   if (b != 0) begin
                  q = sa / sb;
                  r = sa % sb;
                  res = {r[31:0], q[31:0]};
                end
      MD_DIVU:  if (b != 0) res = {a % b, a / b};
      MD_MTHI:  res = {a, l};
      MD_MTLO:  res = {h, a};
      default:  res = {h, l};
    endcase
    return res;
  endfunction

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input logic duse,
                        input int n, input logic flush_mid);
    int cyc;
    int st;
    logic [63:0] exp_q;
    sb_q.push_back(exp);
    start = 1'b1; md_op = op; src_a = a; src_b = b; d_uses_md = duse; flush = 1'b0;
    #1;
    chk({tag, "/stall_start"}, stall, (duse && n > 0));
    tick;
    start = 1'b0;
    src_a = $urandom;
    src_b = $urandom;
    if (n > 0) begin
      cyc = 0;
      st = 0;
      chk({tag, "/old_hilo"}, {hi, lo}, {mdl_hi, mdl_lo});
      while (busy && cyc < 64) begin
        cyc++;
        if (stall) st++;
        if (flush_mid && cyc == 2) flush = 1'b1;
        tick;
        flush = 1'b0;
      end
      chk({tag, "/busy_len"}, cyc, n);
      chk({tag, "/stall_cycles"}, st, duse ? n : 0);
      chk({tag, "/stall_after"}, stall, 1'b0);
    end else begin
      chk({tag, "/busy"}, busy, 1'b0);
    end
    exp_q = sb_q.pop_front();
    chk({tag, "/hilo"}, {hi, lo}, exp_q);
    mdl_hi = exp_q[63:32];
    mdl_lo = exp_q[31:0];
    d_uses_md = 1'b0;
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    tick;
    tick;
    reset = 1'b0;
    chk("reset/hi", hi, 32'd0);
    chk("reset/lo", lo, 32'd0);
    chk("reset/busy", busy, 1'b0);
    chk("reset/stall", stall, 1'b0);

    run_op("mthi", MD_MTHI, 32'h1234_5678, 32'd0, {32'h1234_5678, 32'd0}, 1'b0, 0, 1'b0);
    run_op("mult", MD_MULT, 32'hFFFF_FFFF, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFE}, 1'b0, 5, 1'b0);
    run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, {32'h0000_0001, 32'hFFFF_FFFE}, 1'b0, 5, 1'b0);
    run_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0, 10, 1'b1);
    run_op("div_zero", MD_DIV, 32'd5, 32'd0, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0, 10, 1'b0);
    run_op("mult_mflo", MD_MULT, 32'd3, 32'd4, {32'd0, 32'd12}, 1'b1, 5, 1'b0);

    start = 1'b1; flush = 1'b1; md_op = MD_DIV; src_a = 32'd100; src_b = 32'd3; d_uses_md = 1'b1;
    #1;
    chk("flush/stall", stall, 1'b0);
    tick;
    start = 1'b0; flush = 1'b0; d_uses_md = 1'b0;
    chk("flush/busy", busy, 1'b0);
    tick;
    tick;
    chk("flush/hilo", {hi, lo}, {32'd0, 32'd12});

    run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 1'b0, 10, 1'b0);
    run_op("b2b_mult", MD_MULT, 32'h0001_0000, 32'h0001_0000, {32'd1, 32'd0}, 1'b1, 5, 1'b0);
    run_op("b2b_mtlo", MD_MTLO, 32'hCAFE_F00D, 32'd0, {32'd1, 32'hCAFE_F00D}, 1'b0, 0, 1'b0);

    start = 1'b1; md_op = MD_MULT; src_a = 32'd7; src_b = 32'd9;
    tick;
    start = 1'b0;
    tick;
    tick;
    chk("rst_mid/busy_before", busy, 1'b1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("rst_mid/busy", busy, 1'b0);
    chk("rst_mid/hilo", {hi, lo}, 64'd0);
    repeat (10) tick;
    chk("rst_mid/no_commit", {hi, lo}, 64'd0);
    mdl_hi = 32'd0;
    mdl_lo = 32'd0;

    for (int i = 0; i < 10; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 4) ? 32'd0 : $urandom;
      if (i[0]) rb = rb >> $urandom_range(0, 30);
      run_op("rand", rop, ra, rb, model(rop, ra, rb, mdl_hi, mdl_lo), 1'($urandom_range(0, 1)),
             is_div_op(rop) ? 10 : 5, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
